// File: rtl/z80_wb_arbiter_if.sv
// Bus bundle for the two-master Wishbone arbiter: both master request/return
// groups, the shared slave-side bus and the one-hot grant.
interface z80_wb_arbiter_if;
    // master 0 (z80 core)
    logic        m0_cyc_i;
    logic        m0_stb_i;
    logic        m0_we_i;
    logic [15:0] m0_adr_i;
    logic [1:0]  m0_tga_i;
    logic [7:0]  m0_dat_i;
    logic [7:0]  m0_dat_o;
    logic        m0_ack_o;
    logic        m0_err_o;
    // master 1 (DMA / debug loader)
    logic        m1_cyc_i;
    logic        m1_stb_i;
    logic        m1_we_i;
    logic [15:0] m1_adr_i;
    logic [1:0]  m1_tga_i;
    logic [7:0]  m1_dat_i;
    logic [7:0]  m1_dat_o;
    logic        m1_ack_o;
    logic        m1_err_o;
    // shared bus toward address decode / ack merge
    logic        s_cyc_o;
    logic        s_stb_o;
    logic        s_we_o;
    logic [15:0] s_adr_o;
    logic [1:0]  s_tga_o;
    logic [7:0]  s_dat_o;
    logic [7:0]  s_dat_i;
    logic        s_ack_i;
    logic [1:0]  gnt_o;

    // Arbiter side of the bundle.
    modport slave (
        input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_tga_i, m0_dat_i,
        output m0_dat_o, m0_ack_o, m0_err_o,
        input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_tga_i, m1_dat_i,
        output m1_dat_o, m1_ack_o, m1_err_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_tga_o, s_dat_o,
        input  s_dat_i, s_ack_i,
        output gnt_o
    );

    // Environment side: the masters plus the merged slave response.
    modport master (
        output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_tga_i, m0_dat_i,
        input  m0_dat_o, m0_ack_o, m0_err_o,
        output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_tga_i, m1_dat_i,
        input  m1_dat_o, m1_ack_o, m1_err_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_tga_o, s_dat_o,
        output s_dat_i, s_ack_i,
        input  gnt_o
    );
endinterface

// File: rtl/z80_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter for the z80 slave bus, with a
// registered grant held for the owner's whole cycle and a stalled-strobe watchdog.
module z80_wb_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    z80_wb_arbiter_if.slave   bus
);

    // State encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic               last_gnt_r;
    logic [CNT_W-1:0]   wd_cnt_r;
    logic               sel_stb_s;
    logic               wd_fire_s;
    logic               gnt_change_s;

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    // Next-state arbitration: ties in IDLE go to the master that did not own the bus last.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.m0_cyc_i && bus.m1_cyc_i) begin
                    state_next_s = last_gnt_r ? GNT0 : GNT1;
                end else if (bus.m0_cyc_i) begin
                    state_next_s = GNT0;
                end else if (bus.m1_cyc_i) begin
                    state_next_s = GNT1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            GNT0: begin
                if (bus.m0_cyc_i) begin
                    state_next_s = GNT0;
                end else if (bus.m1_cyc_i) begin
                    state_next_s = GNT1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            GNT1: begin
                if (bus.m1_cyc_i) begin
                    state_next_s = GNT1;
                end else if (bus.m0_cyc_i) begin
                    state_next_s = GNT0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Strobe of the granted master; a strobe without cyc is ignored.
    always_comb begin
        sel_stb_s = 1'b0;
        case (state_r)
            GNT0:    sel_stb_s = bus.m0_cyc_i & bus.m0_stb_i;
            GNT1:    sel_stb_s = bus.m1_cyc_i & bus.m1_stb_i;
            default: sel_stb_s = 1'b0;
        endcase
    end

    // Watchdog fire and grant-change detection.
    always_comb begin
        wd_fire_s    = (wd_cnt_r == WD_LAST) & sel_stb_s & ~bus.s_ack_i;
        gnt_change_s = (state_next_s != state_r);
    end

    // Shared bus forward path: mux of the granted master, all zero when idle.
    always_comb begin
        bus.s_cyc_o = 1'b0;
        bus.s_stb_o = 1'b0;
        bus.s_we_o  = 1'b0;
        bus.s_adr_o = 16'h0000;
        bus.s_tga_o = 2'b00;
        bus.s_dat_o = 8'h00;
        case (state_r)
            GNT0: begin
                bus.s_cyc_o = bus.m0_cyc_i;
                bus.s_stb_o = sel_stb_s & ~wd_fire_s;
                bus.s_we_o  = bus.m0_we_i;
                bus.s_adr_o = bus.m0_adr_i;
                bus.s_tga_o = bus.m0_tga_i;
                bus.s_dat_o = bus.m0_dat_i;
            end
            GNT1: begin
                bus.s_cyc_o = bus.m1_cyc_i;
                bus.s_stb_o = sel_stb_s & ~wd_fire_s;
                bus.s_we_o  = bus.m1_we_i;
                bus.s_adr_o = bus.m1_adr_i;
                bus.s_tga_o = bus.m1_tga_i;
                bus.s_dat_o = bus.m1_dat_i;
            end
            default: begin
                bus.s_cyc_o = 1'b0;
                bus.s_stb_o = 1'b0;
                bus.s_we_o  = 1'b0;
                bus.s_adr_o = 16'h0000;
                bus.s_tga_o = 2'b00;
                bus.s_dat_o = 8'h00;
            end
        endcase
    end

    // Return path; a fire cycle never coincides with s_ack_i, so ack and err stay exclusive.
    always_comb begin
        bus.m0_dat_o = bus.s_dat_i;
        bus.m1_dat_o = bus.s_dat_i;
        bus.m0_ack_o = bus.s_ack_i & state_r[0] & bus.m0_stb_i;
        bus.m1_ack_o = bus.s_ack_i & state_r[1] & bus.m1_stb_i;
        bus.m0_err_o = wd_fire_s & state_r[0];
        bus.m1_err_o = wd_fire_s & state_r[1];
        bus.gnt_o    = state_r;
    end

    // Grant state, round-robin history and watchdog counter.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r    <= IDLE;
            last_gnt_r <= 1'b1;
            wd_cnt_r   <= '0;
        end else begin
            state_r <= state_next_s;
            if (gnt_change_s && (state_next_s == GNT0)) begin
                last_gnt_r <= 1'b0;
            end else if (gnt_change_s && (state_next_s == GNT1)) begin
                last_gnt_r <= 1'b1;
            end else begin
                last_gnt_r <= last_gnt_r;
            end
            if (gnt_change_s || bus.s_ack_i || !sel_stb_s || wd_fire_s) begin
                wd_cnt_r <= '0;
            end else begin
                wd_cnt_r <= wd_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_z80_wb_arbiter.sv
// Scoreboard bench for z80_wb_arbiter: expected acks are queued as stimulus is
// driven and retired by a negedge monitor; grant/bus/watchdog checks are direct.
module tb_z80_wb_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    z80_wb_arbiter_if bus();

    z80_wb_arbiter #(.TIMEOUT(4), .CNT_W(8)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    typedef struct packed {
        logic       m;
        logic [7:0] dat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   errors   = 0;
    int   ack0_cnt = 0;
    int   ack_base = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Ack monitor: every ack must retire the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.m0_ack_o === 1'b1) ack0_cnt++;
        if (bus.m0_ack_o === 1'b1 || bus.m1_ack_o === 1'b1) begin
            check_eq("sb_ack_pending", {31'b0, exp_q.size() > 0}, 32'd1);
            check_eq("sb_ack_onehot", {31'b0, bus.m0_ack_o & bus.m1_ack_o}, 32'd0);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check_eq("sb_ack_master", {31'b0, bus.m1_ack_o}, {31'b0, mon_e.m});
                check_eq("sb_rdata", {24'b0, mon_e.m ? bus.m1_dat_o : bus.m0_dat_o},
                         {24'b0, mon_e.dat});
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_all();
        bus.m0_cyc_i = 1'b0; bus.m0_stb_i = 1'b0; bus.m0_we_i = 1'b0;
        bus.m0_adr_i = 16'h0000; bus.m0_tga_i = 2'b00; bus.m0_dat_i = 8'h00;
        bus.m1_cyc_i = 1'b0; bus.m1_stb_i = 1'b0; bus.m1_we_i = 1'b0;
        bus.m1_adr_i = 16'h0000; bus.m1_tga_i = 2'b00; bus.m1_dat_i = 8'h00;
        bus.s_ack_i  = 1'b0; bus.s_dat_i = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_all();
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        logic exp_err;
        idle_all();

        // Reset state and single m0 read
        do_reset();
        sample();
        check_eq("rst_gnt", {30'b0, bus.gnt_o}, 32'h0);
        check_eq("rst_s_cyc", {31'b0, bus.s_cyc_o}, 32'h0);
        check_eq("rst_s_stb", {31'b0, bus.s_stb_o}, 32'h0);
        next_cycle();
        bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1; bus.m0_adr_i = 16'h0123; bus.m0_tga_i = 2'b00;
        sample();
        check_eq("t1_gnt_latency", {30'b0, bus.gnt_o}, 32'h0);
        next_cycle();
        sample();
        check_eq("t1_gnt", {30'b0, bus.gnt_o}, 32'h1);
        check_eq("t1_adr", {16'b0, bus.s_adr_o}, 32'h0123);
        check_eq("t1_tga", {30'b0, bus.s_tga_o}, 32'h0);
        check_eq("t1_stb", {31'b0, bus.s_stb_o}, 32'h1);
        check_eq("t1_no_early_ack", {31'b0, bus.m0_ack_o}, 32'h0);
        ack_base = ack0_cnt;
        next_cycle();
        bus.s_ack_i = 1'b1; bus.s_dat_i = 8'hA5;
        exp_q.push_back('{m: 1'b0, dat: 8'hA5});
        sample();
        check_eq("t1_dat", {24'b0, bus.m0_dat_o}, 32'hA5);
        next_cycle();
        idle_all();
        sample();
        check_eq("t1_ack_once", ack0_cnt - ack_base, 32'd1);
        check_eq("t1_gnt_hold", {30'b0, bus.gnt_o}, 32'h1);
        next_cycle();
        sample();
        check_eq("t1_gnt_release", {30'b0, bus.gnt_o}, 32'h0);

        // Simultaneous requests: m0 first, zero-idle handover, tie back to m0
        do_reset();
        bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1; bus.m0_adr_i = 16'h1000;
        bus.m1_cyc_i = 1'b1; bus.m1_stb_i = 1'b1; bus.m1_adr_i = 16'h2000;
        sample();
        check_eq("t2_idle", {30'b0, bus.gnt_o}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            bus.s_ack_i = 1'b1; bus.s_dat_i = 8'h11 + 8'(i);
            exp_q.push_back('{m: 1'b0, dat: 8'h11 + 8'(i)});
            sample();
            check_eq("t2_gnt0", {30'b0, bus.gnt_o}, 32'h1);
            check_eq("t2_adr0", {16'b0, bus.s_adr_o}, 32'h1000);
        end
        next_cycle();
        bus.m0_cyc_i = 1'b0; bus.m0_stb_i = 1'b0; bus.s_ack_i = 1'b0;
        sample();
        check_eq("t2_drop_gnt", {30'b0, bus.gnt_o}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            bus.s_ack_i = 1'b1; bus.s_dat_i = 8'h21 + 8'(i);
            exp_q.push_back('{m: 1'b1, dat: 8'h21 + 8'(i)});
            sample();
            check_eq("t2_gnt1", {30'b0, bus.gnt_o}, 32'h2);
            check_eq("t2_adr1", {16'b0, bus.s_adr_o}, 32'h2000);
        end
        next_cycle();
        bus.m1_cyc_i = 1'b0; bus.m1_stb_i = 1'b0; bus.s_ack_i = 1'b0;
        sample();
        check_eq("t2_drop1_gnt", {30'b0, bus.gnt_o}, 32'h2);
        next_cycle();
        bus.m0_cyc_i = 1'b1; bus.m1_cyc_i = 1'b1;
        sample();
        check_eq("t2_back_idle", {30'b0, bus.gnt_o}, 32'h0);
        next_cycle();
        sample();
        check_eq("t2_tie_m0", {30'b0, bus.gnt_o}, 32'h1);
        next_cycle();
        idle_all();
        next_cycle();

        // m1 write with m0 idle
        next_cycle();
        bus.m1_cyc_i = 1'b1; bus.m1_stb_i = 1'b1; bus.m1_we_i = 1'b1;
        bus.m1_adr_i = 16'h8001; bus.m1_tga_i = 2'b01; bus.m1_dat_i = 8'h5A;
        sample();
        check_eq("t3_idle", {30'b0, bus.gnt_o}, 32'h0);
        next_cycle();
        bus.s_ack_i = 1'b1; bus.s_dat_i = 8'h00;
        exp_q.push_back('{m: 1'b1, dat: 8'h00});
        sample();
        check_eq("t3_gnt", {30'b0, bus.gnt_o}, 32'h2);
        check_eq("t3_we", {31'b0, bus.s_we_o}, 32'h1);
        check_eq("t3_wdat", {24'b0, bus.s_dat_o}, 32'h5A);
        check_eq("t3_tga", {30'b0, bus.s_tga_o}, 32'h1);
        check_eq("t3_adr", {16'b0, bus.s_adr_o}, 32'h8001);
        check_eq("t3_m0_ack", {31'b0, bus.m0_ack_o}, 32'h0);
        next_cycle();
        idle_all();
        next_cycle();

        // Watchdog with TIMEOUT=4, and ack landing on the would-be fire cycle
        next_cycle();
        bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1; bus.m0_adr_i = 16'h4000;
        bus.s_dat_i = 8'h3C;
        for (int i = 1; i <= 16; i++) begin
            next_cycle();
            bus.s_ack_i = (i == 12);
            if (i == 12) exp_q.push_back('{m: 1'b0, dat: 8'h3C});
            exp_err = ((i % 4) == 0) && (i != 12);
            sample();
            check_eq("t4_gnt", {30'b0, bus.gnt_o}, 32'h1);
            check_eq("t4_err", {31'b0, bus.m0_err_o}, {31'b0, exp_err});
            check_eq("t4_stb", {31'b0, bus.s_stb_o}, {31'b0, ~exp_err});
            check_eq("t4_m1_err", {31'b0, bus.m1_err_o}, 32'h0);
            check_eq("t4_ack", {31'b0, bus.m0_ack_o}, {31'b0, i == 12});
        end
        next_cycle();
        idle_all();
        next_cycle();

        // Reset during a GNT1 transfer, then tie after release goes to m0
        next_cycle();
        bus.m1_cyc_i = 1'b1; bus.m1_stb_i = 1'b1; bus.m1_adr_i = 16'h9000;
        sample();
        check_eq("t6_idle", {30'b0, bus.gnt_o}, 32'h0);
        next_cycle();
        sample();
        check_eq("t6_gnt1", {30'b0, bus.gnt_o}, 32'h2);
        next_cycle();
        rst = 1'b1;
        sample();
        next_cycle();
        bus.s_ack_i = 1'b1;
        sample();
        check_eq("t6_rst_gnt", {30'b0, bus.gnt_o}, 32'h0);
        check_eq("t6_rst_cyc", {31'b0, bus.s_cyc_o}, 32'h0);
        check_eq("t6_rst_stb", {31'b0, bus.s_stb_o}, 32'h0);
        check_eq("t6_rst_ack", {31'b0, bus.m1_ack_o}, 32'h0);
        check_eq("t6_rst_err", {31'b0, bus.m1_err_o}, 32'h0);
        next_cycle();
        rst = 1'b0; bus.s_ack_i = 1'b0;
        bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1;
        sample();
        check_eq("t6_rel_idle", {30'b0, bus.gnt_o}, 32'h0);
        next_cycle();
        sample();
        check_eq("t6_tie_m0", {30'b0, bus.gnt_o}, 32'h1);
        next_cycle();
        idle_all();
        next_cycle();
        next_cycle();
        sample();
        check_eq("sb_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/z80_wb_arbiter.md
Name: z80_wb_arbiter

Overview:
Two-master Wishbone arbiter that shares the z80 core's slave bus between master 0 (the z80 core) and master 1 (a DMA or debug loader). The shared bus reaches the on-board SRAM, the BIST peripherals and external slaves.
- Round-robin arbitration with registered grant.
- A grant is held for the whole of the owning master's cycle (cyc high).
- A bus watchdog terminates stalled strobes with a one-cycle error.
- Sits between the masters and the address-decode and ack-merge logic at the core top level.

Parameters:
TIMEOUT, 255, number of consecutive unacknowledged strobe cycles before the watchdog fires (1..2^CNT_W-1)
CNT_W, 8, watchdog counter width

Ports:
wb_clk_i  in  1  system clock, all logic rising-edge
wb_rst_i  in  1  synchronous active-high reset
m0_cyc_i  in  1  master 0 cycle
m0_stb_i  in  1  master 0 strobe
m0_we_i  in  1  master 0 write enable
m0_adr_i  in  16  master 0 address
m0_tga_i  in  2  master 0 address tag (00 mem, 01 io, 10 int-ack)
m0_dat_i  in  8  master 0 write data
m0_dat_o  out  8  read data to master 0
m0_ack_o  out  1  ack to master 0
m0_err_o  out  1  watchdog error to master 0
m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i[15:0], m1_tga_i[1:0], m1_dat_i[7:0]  in  master 1 request, same meaning as the m0 inputs
m1_dat_o  out  8  read data to master 1
m1_ack_o  out  1  ack to master 1
m1_err_o  out  1  watchdog error to master 1
s_cyc_o  out  1  shared bus cycle
s_stb_o  out  1  shared bus strobe
s_we_o  out  1  shared bus write enable
s_adr_o  out  16  shared bus address
s_tga_o  out  2  shared bus address tag
s_dat_o  out  8  shared bus write data
s_dat_i  in  8  merged read data
s_ack_i  in  1  merged ack
gnt_o  out  2  one-hot current grant (00 = idle)

Behaviour:
- Reset and clocking: one clock (wb_clk_i); reset (wb_rst_i) is synchronous and active-high. Reset forces:
  - state IDLE, gnt_o=00
  - last_gnt=1, so master 0 wins the first tie
  - watchdog counter=0
- States and transitions: IDLE, GNT0, GNT1; state is registered.
  - IDLE: m0_cyc only -> GNT0. m1_cyc only -> GNT1. Both -> the master not equal to last_gnt. Neither -> stay IDLE.
  - GNTx: stay while mx_cyc_i=1. When mx_cyc_i=0, go directly to GNTy if my_cyc_i=1, else to IDLE.
  - last_gnt updates to x on every entry to GNTx.
- Arbitration latency: one cycle from cyc assertion (in IDLE) to grant. Masters hold their request until ack or err.
- Shared bus outputs:
  - In GNTx, s_* are a combinational mux of master x's inputs. s_stb_o = mx_stb_i & ~wd_fire.
  - In IDLE, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_tga_o and s_dat_o are all 0.
- Return path to masters:
  - m0_dat_o and m1_dat_o = s_dat_i always.
  - mx_ack_o = s_ack_i & gnt_o[x] & mx_stb_i.
  - The non-granted master sees ack=0 and err=0.
- Watchdog:
  - The counter increments each cycle the granted master has stb=1 and s_ack_i=0.
  - It clears on s_ack_i, on grant change, or when stb=0.
  - wd_fire = (counter == TIMEOUT-1) & stb & ~s_ack_i, combinational.
  - When wd_fire: mx_err_o=1 for that cycle, s_stb_o is forced 0, counter clears.
  - ack and err are mutually exclusive; s_ack_i in the fire cycle wins and err stays 0.
- Handover and mid-cycle reset:
  - A master that drops cyc in the same cycle as its ack loses the grant at the next edge. The other requester gets the bus with zero idle cycles.
  - Reset mid-cycle aborts the transfer: the shared bus goes idle on the next edge and no ack or err is generated.
- Master behaviour outside the protocol:
  - If a master raises stb without cyc, it is ignored.
  - If a master changes address mid-strobe, it is passed through unchanged; no checking is done.

Test Plan:
- Reset, then m0 reads addr 0x0123 with s_ack_i after 2 cycles -> gnt_o=01 one cycle after cyc; s_adr_o=0x0123, s_tga_o=00; m0_ack_o pulses once; m0_dat_o=s_dat_i=0xA5.
- m0 and m1 raise cyc in the same cycle, both holding for 3 transfers -> m0 granted first (last_gnt=1 after reset). On m0 cyc drop, gnt_o=10 on the very next cycle. The next tie after both finish goes to m0 again.
- m1 writes 0x5A to 0x8001 with tga=01 while m0 idle -> s_we_o=1, s_dat_o=0x5A, s_tga_o=01. m0_ack_o stays 0 even though s_ack_i=1.
- TIMEOUT=4, m0 strobes with s_ack_i held 0 -> m0_err_o=1 on the 4th strobe cycle with s_stb_o=0 that cycle. The counter restarts and err repeats every 4 cycles while stb is held.
- s_ack_i asserted exactly on the would-be fire cycle -> m0_ack_o=1, m0_err_o=0, counter cleared.
- Assert wb_rst_i during a GNT1 transfer -> next edge gnt_o=00, s_cyc_o=0, no ack or err to m1. After reset release, a simultaneous request is granted to m0.
